pwm_reg_bank: RTL

Clock-domain register bank and two-channel 8-bit PWM generator that sits directly downstream of the SPI slave. It receives register writes from the SCLK domain over a toggle handshake and synchronizes them into `clk`. It holds the four device registers, returns read data to the SPI slave, and drives the PWM outputs onto `uo_out`.

---
 rtl/pwm_reg_bank.sv | 112 +++++++++++
 1 files changed

// File: rtl/pwm_reg_bank.sv
// pwm_reg_bank: toggle-handshake register bank feeding a two-channel 8-bit PWM.
// Optional period-boundary duty shadowing is enabled by defining PWM_SHADOW_EN.
module pwm_reg_bank #(
  parameter int         PRESCALE = 4,
  parameter logic [7:0] ID_VALUE = 8'h96
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_tgl,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [1:0] pwm_out
);

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  logic       r_s1, r_s2, r_s3;
  logic       w_wr_stb;
  logic [7:0] r_ctrl, r_duty0, r_duty1;
  logic [7:0] r_pre, r_cnt;
  logic       w_tick, w_wrap;
  logic [7:0] w_act0, w_act1;
  logic [1:0] w_raw;

  // s3 doubles as the acknowledge toggle returned to the SCLK side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= wr_tgl;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_wr_stb = r_s2 ^ r_s3;
  assign wr_ack   = r_s3;

  // Address/data are held stable by the SCLK side until the ack, so no sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= 8'h00;
      r_duty0 <= 8'h00;
      r_duty1 <= 8'h00;
    end else if (w_wr_stb) begin
      case (wr_addr)
        2'd1:    r_ctrl  <= wr_data;
        2'd2:    r_duty0 <= wr_data;
        2'd3:    r_duty1 <= wr_data;
        default: ;
      endcase
    end
  end

  assign w_tick = (r_pre == PRE_LAST);
  assign w_wrap = w_tick && (r_cnt == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= 8'h00;
      r_cnt <= 8'h00;
    end else begin
      r_pre <= w_tick ? 8'h00 : r_pre + 8'h01;
      if (w_tick) r_cnt <= r_cnt + 8'h01;
    end
  end

`ifdef PWM_SHADOW_EN
  logic [7:0] r_sh0, r_sh1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh0 <= 8'h00;
      r_sh1 <= 8'h00;
    end else if (w_wrap) begin
      r_sh0 <= r_duty0;
      r_sh1 <= r_duty1;
    end
  end

  assign w_act0 = r_sh0;
  assign w_act1 = r_sh1;
`else
  logic w_unused_wrap;
  assign w_unused_wrap = w_wrap;
  assign w_act0 = r_duty0;
  assign w_act1 = r_duty1;
`endif

  assign w_raw[0] = r_ctrl[0] && (r_cnt < w_act0);
  assign w_raw[1] = r_ctrl[1] && (r_cnt < w_act1);

  // A disabled channel sits at its idle level, which is the polarity bit.
  assign pwm_out[0] = r_ctrl[0] ? (w_raw[0] ^ r_ctrl[2]) : r_ctrl[2];
  assign pwm_out[1] = r_ctrl[1] ? (w_raw[1] ^ r_ctrl[2]) : r_ctrl[2];

  always_comb begin
    rd_data = ID_VALUE;
    case (rd_addr)
      2'd1:    rd_data = r_ctrl;
      2'd2:    rd_data = r_duty0;
      2'd3:    rd_data = r_duty1;
      default: rd_data = ID_VALUE;
    endcase
  end

endmodule
